int_priority_ctrl: RTL
======================

// Module: int_priority_ctrl
// PURPOSE
//  8051 interrupt priority controller; direct upstream stage of the instruction-extension decoder.
//  Latches five interrupt sources, resolves two-level priority against the in-service state.
//  Drives INT_REQ and INT_LEVEL to the decoder and INT_VECT to the LCALL generator.
//  Tracks nesting via INT_ACK (vector taken) and RETI (return executed).
// PARAMETERS
//  NUM_SRC   5     interrupt sources; idx 0=IE0, 1=TF0, 2=IE1, 3=TF1, 4=RI|TI
//  VECT_BASE 8'h03 vector of source 0; source n vectors to VECT_BASE + 8*n
// PORTS
//  CLK        in   1  system clock, all state on rising edge
//  RST        in   1  synchronous reset, active high
//  EA         in   1  global enable (IE.7)
//  IE_MASK    in   5  per-source enables (IE.4..0)
//  IP         in   5  per-source priority, 1 = high (IP.4..0)
//  IT0, IT1   in   1  1 = falling-edge mode, 0 = low-level mode for INT0_N / INT1_N
//  INT0_N     in   1  external interrupt pin 0, active low
//  INT1_N     in   1  external interrupt pin 1, active low
//  TF0, TF1   in   1  timer overflow flags from timer block
//  SER_INT    in   1  RI|TI from serial port
//  INT_BLOCK  in   1  core is executing RETI or an IE/IP write; suppresses new INT_REQ
//  INT_ACK    in   1  one-cycle pulse: core has begun the vector LCALL
//  RETI       in   1  one-cycle pulse: RETI completed
//  INT_REQ    out  1  registered request to decoder
//  INT_LEVEL  out  2  {high-level in service, low-level in service}
//  INT_VECT   out  8  vector of winning source, valid while INT_REQ=1
//  IE0, IE1   out  1  external flags (TCON.1 / TCON.3 readback)
//  TF0_CLR    out  1  one-cycle pulse: clear TF0 in timer block
//  TF1_CLR    out  1  one-cycle pulse: clear TF1 in timer block
// BEHAVIOUR
//  Reset: INT_REQ=0, INT_LEVEL=2'b00, INT_VECT=VECT_BASE, IE0=IE1=0, TF*_CLR=0, pin history=1.
//  Ext flags: edge mode sets IEx when prev pin=1 and cur pin=0; cleared by INT_ACK of that source.
//    Level mode IEx = registered ~INTx_N every cycle; ACK has no effect.
//    Edge set and ACK clear in same cycle: set wins.
//  Pending[n] = flag[n] & IE_MASK[n] & EA.
//  Winner: any pending high-priority source beats any low; ties broken by lowest index.
//  Eligible: winner high and INT_LEVEL[1]=0, or winner low and INT_LEVEL==2'b00.
//  INT_REQ(next) = eligible & ~INT_BLOCK & ~INT_ACK & ~RETI; 1-cycle latency from a flag.
//  INT_VECT registered together with INT_REQ; frozen while INT_REQ=1 until ACK.
//  INT_ACK when INT_REQ=1 sets INT_LEVEL bit for captured source priority, clears INT_REQ next cycle.
//    Same ACK clears IEx (edge) or pulses TFx_CLR for 1 cycle; serial flag never cleared here.
//  INT_ACK when INT_REQ=0: ignored.
//  RETI clears INT_LEVEL[1] if set, else INT_LEVEL[0]; RETI at 2'b00 is a no-op.
//  RETI+ACK same cycle: clear applied first, then set; net level = (level w/ RETI clear) | ack bit.
//  Mid-request IE/EA drop: INT_REQ deasserts next cycle, no state lost.
//  Reset mid-service: all in-service bits and flags cleared.
// CONFIGURATION
//  INT_PIN_SYNC_EN defined: INT0_N/INT1_N pass 2-flop synchronizer before edge/level logic.
//    Adds 2 cycles pin-to-flag latency; sync flops reset to 1.
//  INT_PIN_SYNC_EN undefined: pins sampled by a single register; 1 cycle pin-to-flag.
// TESTING
//  EA=1, IE_MASK=5'h02, TF0 pulse -> INT_REQ=1 next cycle, INT_VECT=8'h0B.
//    ACK -> TF0_CLR pulse, INT_LEVEL=01, INT_REQ=0.
//  Low T0 in service, IP=5'h04, IT1=1, INT1_N falls -> INT_REQ, INT_VECT=8'h13.
//    ACK -> INT_LEVEL=11.
//    RETI -> 01; RETI -> 00.
//  IE0 and TF1 pending, IP=5'h08 -> INT_VECT=8'h1B (high TF1 beats low IE0).
//    After ACK+RETI -> INT_VECT=8'h03.
//  INT_LEVEL=10, low SER_INT pending -> INT_REQ stays 0; RETI -> INT_REQ=1, INT_VECT=8'h23.
//  IT0=0, INT0_N held low across ACK+RETI -> IE0 stays 1, request re-raised.
//    INT_BLOCK=1 for 1 cycle -> INT_REQ low that cycle only.
//  RST asserted with INT_LEVEL=11, IE0=1 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/int_priority_ctrl.sv
// ---------------------------------------------------------------------------
// int_priority_ctrl
//   8051-style two-level interrupt priority controller. Latches the five
//   interrupt sources (IE0, TF0, IE1, TF1, RI|TI), picks a winner against the
//   in-service state and presents a registered request + vector to the core.
//   Nesting is tracked through int_ack (vector LCALL started) and reti.
//
// Optional feature macro:
//   INT_PIN_SYNC_EN - when defined, int0_n/int1_n pass a 2-flop synchronizer
//                     (reset to 1) before the edge/level logic, adding two
//                     cycles of pin-to-flag latency.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        synchronous reset, active high
//   ea         global interrupt enable
//   ie_mask    per-source enables
//   ip         per-source priority, 1 = high
//   it0, it1   1 = falling-edge mode, 0 = low-level mode for int0_n / int1_n
//   int0_n     external interrupt pin 0, active low
//   int1_n     external interrupt pin 1, active low
//   tf0, tf1   timer overflow flags
//   ser_int    serial port RI|TI
//   int_block  suppresses new requests (RETI / IE / IP write in progress)
//   int_ack    one-cycle pulse: core has begun the vector LCALL
//   reti       one-cycle pulse: RETI completed
//   int_req    registered request to the decoder
//   int_level  {high-level in service, low-level in service}
//   int_vect   vector of the winning source, valid while int_req = 1
//   ie0, ie1   external interrupt flags (readback)
//   tf0_clr    one-cycle pulse: clear TF0 in the timer block
//   tf1_clr    one-cycle pulse: clear TF1 in the timer block
// ---------------------------------------------------------------------------
module int_priority_ctrl #(
    parameter int         NUM_SRC   = 5,
    parameter logic [7:0] VECT_BASE = 8'h03
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ea,
    input  logic [NUM_SRC-1:0] ie_mask,
    input  logic [NUM_SRC-1:0] ip,
    input  logic               it0,
    input  logic               it1,
    input  logic               int0_n,
    input  logic               int1_n,
    input  logic               tf0,
    input  logic               tf1,
    input  logic               ser_int,
    input  logic               int_block,
    input  logic               int_ack,
    input  logic               reti,
    output logic               int_req,
    output logic [1:0]         int_level,
    output logic [7:0]         int_vect,
    output logic               ie0,
    output logic               ie1,
    output logic               tf0_clr,
    output logic               tf1_clr
);

    localparam int IDX_W = 3;

    // ---------------- pin front end ----------------
    logic int0_cur;
    logic int1_cur;

`ifdef INT_PIN_SYNC_EN
    logic [1:0] int0_sync_reg;
    logic [1:0] int1_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            int0_sync_reg <= 2'b11;
            int1_sync_reg <= 2'b11;
        end else begin
            int0_sync_reg <= {int0_sync_reg[0], int0_n};
            int1_sync_reg <= {int1_sync_reg[0], int1_n};
        end
    end

    assign int0_cur = int0_sync_reg[1];
    assign int1_cur = int1_sync_reg[1];
`else
    assign int0_cur = int0_n;
    assign int1_cur = int1_n;
`endif

    // ---------------- state ----------------
    logic             int0_prev_reg, int1_prev_reg;
    logic             ie0_reg, ie1_reg;
    logic             ie0_next, ie1_next;
    logic             req_reg, req_next;
    logic [1:0]       level_reg, level_next;
    logic [7:0]       vect_reg, vect_next;
    logic [IDX_W-1:0] idx_reg;
    logic             prio_reg;
    logic             tf0_clr_reg, tf1_clr_reg;

    logic [NUM_SRC-1:0] flag;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] sel;
    logic [IDX_W-1:0]   win_idx;
    logic               win_hi;
    logic               eligible;
    logic               ack_valid;
    logic               capture;
    logic [1:0]         level_after_reti;

    assign flag = {ser_int, tf1, ie1_reg, tf0, ie0_reg};

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            assign pending[gi] = flag[gi] & ie_mask[gi] & ea;
        end
    endgenerate

    // An ACK only counts when a request is actually being presented.
    assign ack_valid = int_ack & req_reg;

    // Winner: high-priority pending sources mask out all low ones; lowest
    // index wins within the selected group.
    always_comb begin
        win_hi  = |(pending & ip);
        sel     = win_hi ? (pending & ip) : pending;
        win_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (sel[i]) win_idx = IDX_W'(i);
        end
        eligible = (|pending) & (win_hi ? ~level_reg[1] : (level_reg == 2'b00));
    end

    // External flags. Edge mode: a new falling edge beats a same-cycle ACK.
    always_comb begin
        if (it0) begin
            ie0_next = (int0_prev_reg & ~int0_cur) |
                       (ie0_reg & ~(ack_valid && idx_reg == IDX_W'(0)));
        end else begin
            ie0_next = ~int0_cur;
        end
        if (it1) begin
            ie1_next = (int1_prev_reg & ~int1_cur) |
                       (ie1_reg & ~(ack_valid && idx_reg == IDX_W'(2)));
        end else begin
            ie1_next = ~int1_cur;
        end
    end

    // Level tracking: RETI retires the highest active level first, then an
    // accepted ACK adds the level of the captured source.
    always_comb begin
        level_after_reti = level_reg;
        if (reti) level_after_reti = level_reg[1] ? {1'b0, level_reg[0]} : 2'b00;
        level_next = level_after_reti;
        if (ack_valid) level_next = level_after_reti | (prio_reg ? 2'b10 : 2'b01);
    end

    // Vector/source/priority are frozen while a request is outstanding so the
    // ACK always refers to what the core saw.
    assign capture   = ~req_reg | ack_valid;
    assign req_next  = eligible & ~int_block & ~int_ack & ~reti;
    assign vect_next = VECT_BASE + {2'b00, win_idx, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            int0_prev_reg <= 1'b1;
            int1_prev_reg <= 1'b1;
            ie0_reg       <= 1'b0;
            ie1_reg       <= 1'b0;
            req_reg       <= 1'b0;
            level_reg     <= 2'b00;
            vect_reg      <= VECT_BASE;
            idx_reg       <= '0;
            prio_reg      <= 1'b0;
            tf0_clr_reg   <= 1'b0;
            tf1_clr_reg   <= 1'b0;
        end else begin
            int0_prev_reg <= int0_cur;
            int1_prev_reg <= int1_cur;
            ie0_reg       <= ie0_next;
            ie1_reg       <= ie1_next;
            req_reg       <= req_next;
            level_reg     <= level_next;
            if (capture) begin
                vect_reg <= vect_next;
                idx_reg  <= win_idx;
                prio_reg <= win_hi;
            end
            tf0_clr_reg   <= ack_valid && (idx_reg == IDX_W'(1));
            tf1_clr_reg   <= ack_valid && (idx_reg == IDX_W'(3));
        end
    end

    assign int_req   = req_reg;
    assign int_level = level_reg;
    assign int_vect  = vect_reg;
    assign ie0       = ie0_reg;
    assign ie1       = ie1_reg;
    assign tf0_clr   = tf0_clr_reg;
    assign tf1_clr   = tf1_clr_reg;

endmodule
